// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared definitions for the hook release / pull-back controllers:
//   - release FSM state encoding
//   - sprite / object type codes used by the draw engine and object table
//   - field slices of the packed 27-bit object-location word
//       {w[26:22], x[21:13], h[12:8], y[7:0]}
// ---------------------------------------------------------------------------
package game_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAW,
        ST_WAIT_STEP,
        ST_ERASE,
        ST_SCAN_RESET,
        ST_SCAN_WAIT,
        ST_SCAN_CMP,
        ST_SCAN_NEXT,
        ST_MOVE,
        ST_LATCH,
        ST_HANDOFF,
        ST_WAIT_PB,
        ST_DONE
    } release_state_t;

    localparam logic [4:0] TYPE_NONE        = 5'd0;
    localparam logic [4:0] TYPE_GOLD_MEDIUM = 5'd10;
    localparam logic [4:0] TYPE_GOLD_LARGE  = 5'd11;
    localparam logic [4:0] TYPE_HOOK        = 5'd12;
    localparam logic [4:0] TYPE_ROCK_LARGE  = 5'd13;
    localparam logic [4:0] TYPE_ROCK_MEDIUM = 5'd14;

    localparam int LOC_W_HI = 26;
    localparam int LOC_W_LO = 22;
    localparam int LOC_X_HI = 21;
    localparam int LOC_X_LO = 13;
    localparam int LOC_H_HI = 12;
    localparam int LOC_H_LO = 8;
    localparam int LOC_Y_HI = 7;
    localparam int LOC_Y_LO = 0;

    function automatic logic [4:0] loc_w(input logic [26:0] loc);
        return loc[LOC_W_HI:LOC_W_LO];
    endfunction

    function automatic logic [8:0] loc_x(input logic [26:0] loc);
        return loc[LOC_X_HI:LOC_X_LO];
    endfunction

    function automatic logic [4:0] loc_h(input logic [26:0] loc);
        return loc[LOC_H_HI:LOC_H_LO];
    endfunction

    function automatic logic [7:0] loc_y(input logic [26:0] loc);
        return loc[LOC_Y_HI:LOC_Y_LO];
    endfunction

endpackage

// File: rtl/hook_hit_compare.sv
// ---------------------------------------------------------------------------
// hook_hit_compare
// Combinational bounding-box test of the hook tip against one object entry.
// Must stay semantically identical to the comparison used on pull-back.
//   location : packed object-location word {w, x, h, y}
//   x        : hook x (9-bit)
//   tip_y    : hook tip y (9-bit, already offset, no wrap)
//   hit      : obj_y <= tip_y <= obj_y+h  and  obj_x <= x <= obj_x+w
// Object presence is qualified by the caller.
// ---------------------------------------------------------------------------
module hook_hit_compare
    import game_pkg::*;
(
    input  logic [26:0] location,
    input  logic [8:0]  x,
    input  logic [8:0]  tip_y,
    output logic        hit
);

    logic [8:0] obj_x;
    logic [7:0] obj_y;
    logic [4:0] obj_w;
    logic [4:0] obj_h;
    logic [9:0] x_right;
    logic [8:0] y_low;

    assign obj_x = loc_x(location);
    assign obj_y = loc_y(location);
    assign obj_w = loc_w(location);
    assign obj_h = loc_h(location);

    // Widened sums so the far edges never wrap.
    assign x_right = {1'b0, obj_x} + {5'b0, obj_w};
    assign y_low   = {1'b0, obj_y} + {4'b0, obj_h};

    assign hit = (tip_y >= {1'b0, obj_y}) && (tip_y <= y_low) &&
                 (x >= obj_x) && ({1'b0, x} <= x_right);

endmodule

// File: rtl/hook_release_control.sv
// ---------------------------------------------------------------------------
// hook_release_control
// Drives the hook downward one row per step from its launch point. Each step:
// draw hook, wait STEP_CYCLES, erase hook, scan the object table for a hit
// at the hook tip. A hit, or reaching the bottom / a side edge, latches the
// release point and hit type, pulses start_pull_back, then waits for
// pull_back_done before pulsing release_done and returning to idle.
//
// Ports:
//   clk, resetn (sync, active-low)
//   start_release, launch_x, launch_y, dir_x   : launch request + parameters
//   start_draw_hook, erase_hook, hook_x, hook_y,
//   draw_type, draw_object_done                : draw-engine handshake
//   reset_object_read, read_object_location,
//   object_location_length, object_type,
//   object_present                             : object-table read port
//   current_release_x/y, reach_bottom,
//   type_reached                               : latched release result
//   start_pull_back, pull_back_done            : pull-back handoff
//   release_done                               : end-of-release pulse
// ---------------------------------------------------------------------------
module hook_release_control
    import game_pkg::*;
#(
    parameter int         STEP_CYCLES = 1562500,
    parameter int         NUM_OBJECTS = 12,
    parameter logic [7:0] Y_BOTTOM    = 8'd230,
    parameter logic [8:0] X_MIN       = 9'd4,
    parameter logic [8:0] X_MAX       = 9'd312,
    parameter logic [3:0] TIP_OFFSET  = 4'd10
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start_release,
    input  logic [8:0]  launch_x,
    input  logic [7:0]  launch_y,
    input  logic [2:0]  dir_x,
    output logic        start_draw_hook,
    output logic        erase_hook,
    output logic [8:0]  hook_x,
    output logic [7:0]  hook_y,
    output logic [4:0]  draw_type,
    input  logic        draw_object_done,
    output logic        reset_object_read,
    output logic        read_object_location,
    input  logic [26:0] object_location_length,
    input  logic [4:0]  object_type,
    input  logic        object_present,
    output logic [8:0]  current_release_x,
    output logic [7:0]  current_release_y,
    output logic        reach_bottom,
    output logic [4:0]  type_reached,
    output logic        start_pull_back,
    input  logic        pull_back_done,
    output logic        release_done
);

    localparam int CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int IDX_W = (NUM_OBJECTS > 1) ? $clog2(NUM_OBJECTS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_OBJECTS - 1);

    release_state_t state_reg, state_next;

    logic [8:0]       x_cur_reg;
    logic [7:0]       y_cur_reg;
    logic [2:0]       dir_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [IDX_W-1:0] idx_reg;
    logic [8:0]       rel_x_reg;
    logic [7:0]       rel_y_reg;
    logic             reach_bottom_reg;
    logic [4:0]       type_reached_reg;

    logic [8:0]         tip_y;
    logic               geom_hit;
    logic               hit;
    logic [8:0]         y_next;
    logic signed [10:0] x_next;
    logic               stop_edge;
    logic               drawing;

    // Tip is computed in 9 bits so a hook near the bottom never wraps to 0.
    assign tip_y = {1'b0, y_cur_reg} + {5'b0, TIP_OFFSET};

    hook_hit_compare u_hit (
        .location (object_location_length),
        .x        (x_cur_reg),
        .tip_y    (tip_y),
        .hit      (geom_hit)
    );

    assign hit = object_present && geom_hit;

    // Signed sum with headroom: a step past x=0 becomes negative and so
    // counts as having reached the left edge.
    assign y_next = {1'b0, y_cur_reg} + 9'd1;
    assign x_next = $signed({2'b00, x_cur_reg}) + $signed({{8{dir_reg[2]}}, dir_reg});
    assign stop_edge = (y_next >= {1'b0, Y_BOTTOM}) ||
                       (x_next <= $signed({2'b00, X_MIN})) ||
                       (x_next >= $signed({2'b00, X_MAX}));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and Moore strobes.
    always_comb begin
        state_next           = state_reg;
        start_draw_hook      = 1'b0;
        erase_hook           = 1'b0;
        reset_object_read    = 1'b0;
        read_object_location = 1'b0;
        start_pull_back      = 1'b0;
        release_done         = 1'b0;
        drawing              = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start_release) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_next = ST_DRAW;
            end
            ST_DRAW: begin
                start_draw_hook = 1'b1;
                drawing         = 1'b1;
                if (draw_object_done) begin
                    state_next = ST_WAIT_STEP;
                end
            end
            ST_WAIT_STEP: begin
                if (cnt_reg == CNT_LAST) begin
                    state_next = ST_ERASE;
                end
            end
            ST_ERASE: begin
                start_draw_hook = 1'b1;
                erase_hook      = 1'b1;
                drawing         = 1'b1;
                if (draw_object_done) begin
                    state_next = ST_SCAN_RESET;
                end
            end
            ST_SCAN_RESET: begin
                reset_object_read = 1'b1;
                state_next        = ST_SCAN_WAIT;
            end
            ST_SCAN_WAIT: begin
                state_next = ST_SCAN_CMP;
            end
            ST_SCAN_CMP: begin
                if (hit) begin
                    state_next = ST_LATCH;
                end else if (idx_reg == IDX_LAST) begin
                    state_next = ST_MOVE;
                end else begin
                    state_next = ST_SCAN_NEXT;
                end
            end
            ST_SCAN_NEXT: begin
                read_object_location = 1'b1;
                state_next           = ST_SCAN_WAIT;
            end
            ST_MOVE: begin
                state_next = stop_edge ? ST_LATCH : ST_DRAW;
            end
            ST_LATCH: begin
                state_next = ST_HANDOFF;
            end
            ST_HANDOFF: begin
                start_pull_back = 1'b1;
                state_next      = ST_WAIT_PB;
            end
            ST_WAIT_PB: begin
                if (pull_back_done) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                release_done = 1'b1;
                state_next   = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // The draw engine needs the sprite type for both drawing and erasing,
    // since the erase paints background over the same sprite footprint.
    assign hook_x    = drawing ? x_cur_reg : 9'd0;
    assign hook_y    = drawing ? y_cur_reg : 8'd0;
    assign draw_type = drawing ? TYPE_HOOK : TYPE_NONE;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            x_cur_reg        <= 9'd0;
            y_cur_reg        <= 8'd0;
            dir_reg          <= 3'd0;
            cnt_reg          <= '0;
            idx_reg          <= '0;
            rel_x_reg        <= 9'd0;
            rel_y_reg        <= 8'd0;
            reach_bottom_reg <= 1'b0;
            type_reached_reg <= 5'd0;
        end else begin
            case (state_reg)
                ST_LOAD: begin
                    x_cur_reg        <= launch_x;
                    y_cur_reg        <= launch_y;
                    dir_reg          <= dir_x;
                    rel_x_reg        <= 9'd0;
                    rel_y_reg        <= 8'd0;
                    reach_bottom_reg <= 1'b0;
                    type_reached_reg <= 5'd0;
                end
                ST_DRAW: begin
                    // Counter is armed here so WAIT_STEP starts from zero.
                    cnt_reg <= '0;
                end
                ST_WAIT_STEP: begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
                ST_SCAN_RESET: begin
                    idx_reg <= '0;
                end
                ST_SCAN_CMP: begin
                    if (hit) begin
                        type_reached_reg <= object_type;
                    end
                end
                ST_SCAN_NEXT: begin
                    idx_reg <= idx_reg + IDX_W'(1);
                end
                ST_MOVE: begin
                    if (stop_edge) begin
                        reach_bottom_reg <= 1'b1;
                    end else begin
                        x_cur_reg <= x_next[8:0];
                        y_cur_reg <= y_next[7:0];
                    end
                end
                ST_LATCH: begin
                    rel_x_reg <= x_cur_reg;
                    rel_y_reg <= y_cur_reg;
                end
                default: begin
                end
            endcase
        end
    end

    assign current_release_x = rel_x_reg;
    assign current_release_y = rel_y_reg;
    assign reach_bottom      = reach_bottom_reg;
    assign type_reached      = type_reached_reg;

endmodule

// File: tb/tb_hook_release_control.sv
// ---------------------------------------------------------------------------
// tb_hook_release_control
// Bench for hook_release_control with STEP_CYCLES=4. Models the draw engine
// (fixed 3-cycle draw), the object table (pointer rewound / advanced by the
// DUT strobes) and the pull-back controller (held-off done pulse). A
// step-level model predicts every draw/erase position, the number of table
// advances per scan and the release result.
// ---------------------------------------------------------------------------
module tb_hook_release_control;

    localparam int STEP = 4;
    localparam int NOBJ = 12;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start_release = 1'b0;
    logic [8:0]  launch_x = 9'd0;
    logic [7:0]  launch_y = 8'd0;
    logic [2:0]  dir_x = 3'd0;
    logic        start_draw_hook;
    logic        erase_hook;
    logic [8:0]  hook_x;
    logic [7:0]  hook_y;
    logic [4:0]  draw_type;
    logic        draw_object_done = 1'b0;
    logic        reset_object_read;
    logic        read_object_location;
    logic [26:0] object_location_length;
    logic [4:0]  object_type;
    logic        object_present;
    logic [8:0]  current_release_x;
    logic [7:0]  current_release_y;
    logic        reach_bottom;
    logic [4:0]  type_reached;
    logic        start_pull_back;
    logic        pull_back_done = 1'b0;
    logic        release_done;

    hook_release_control #(.STEP_CYCLES(STEP), .NUM_OBJECTS(NOBJ)) dut (
        .clk                    (clk),
        .resetn                 (resetn),
        .start_release          (start_release),
        .launch_x               (launch_x),
        .launch_y               (launch_y),
        .dir_x                  (dir_x),
        .start_draw_hook        (start_draw_hook),
        .erase_hook             (erase_hook),
        .hook_x                 (hook_x),
        .hook_y                 (hook_y),
        .draw_type              (draw_type),
        .draw_object_done       (draw_object_done),
        .reset_object_read      (reset_object_read),
        .read_object_location   (read_object_location),
        .object_location_length (object_location_length),
        .object_type            (object_type),
        .object_present         (object_present),
        .current_release_x      (current_release_x),
        .current_release_y      (current_release_y),
        .reach_bottom           (reach_bottom),
        .type_reached           (type_reached),
        .start_pull_back        (start_pull_back),
        .pull_back_done         (pull_back_done),
        .release_done           (release_done)
    );

    initial forever #5 clk = ~clk;

    // ---------------- object table ----------------
    logic [4:0] t_w [NOBJ];
    logic [8:0] t_x [NOBJ];
    logic [4:0] t_h [NOBJ];
    logic [7:0] t_y [NOBJ];
    logic [4:0] t_type [NOBJ];
    logic       t_p [NOBJ];
    logic [3:0] mptr = 4'd0;

    assign object_location_length = {t_w[mptr], t_x[mptr], t_h[mptr], t_y[mptr]};
    assign object_type            = t_type[mptr];
    assign object_present         = t_p[mptr];

    task automatic clear_table();
        for (int i = 0; i < NOBJ; i++) begin
            t_w[i] = 5'd0; t_x[i] = 9'd0; t_h[i] = 5'd0;
            t_y[i] = 8'd0; t_type[i] = 5'd0; t_p[i] = 1'b0;
        end
    endtask

    task automatic set_entry(input int i, input int w, input int x, input int h,
                             input int y, input int ty, input bit p);
        t_w[i] = 5'(w); t_x[i] = 9'(x); t_h[i] = 5'(h);
        t_y[i] = 8'(y); t_type[i] = 5'(ty); t_p[i] = p;
    endtask

    initial forever begin
        @(negedge clk);
        if (reset_object_read) mptr = 4'd0;
        else if (read_object_location && mptr < 4'(NOBJ - 1)) mptr = mptr + 4'd1;
    end

    // ---------------- draw engine: done after 3 cycles of request ----------------
    initial begin
        int dcnt;
        dcnt = 0;
        forever begin
            @(negedge clk);
            if (draw_object_done) begin
                draw_object_done = 1'b0;
            end else if (start_draw_hook) begin
                dcnt++;
                if (dcnt == 3) begin
                    draw_object_done = 1'b1;
                    dcnt = 0;
                end
            end else begin
                dcnt = 0;
            end
        end
    end

    // ---------------- scoring ----------------
    int n_cmp  = 0;
    int n_fail = 0;
    int n_draws = 0, n_erases = 0, n_pb = 0;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // ---------------- step-level model ----------------
    typedef struct { int x; int y; bit er; } draw_t;
    draw_t exp_q[$];
    int    exp_reads_q[$];
    int    e_rx, e_ry, e_type;
    bit    e_bot;

    task automatic model_run(input int x0, input int y0, input int d);
        int x, y, hit, tip;
        draw_t e;
        x = x0; y = y0;
        exp_q.delete();
        exp_reads_q.delete();
        for (int s = 0; s < 400; s++) begin
            e.x = x; e.y = y; e.er = 1'b0; exp_q.push_back(e);
            e.er = 1'b1; exp_q.push_back(e);
            tip = y + 10;
            hit = -1;
            for (int i = 0; i < NOBJ; i++) begin
                if (hit < 0 && t_p[i] &&
                    tip >= int'(t_y[i]) && tip <= int'(t_y[i]) + int'(t_h[i]) &&
                    x >= int'(t_x[i]) && x <= int'(t_x[i]) + int'(t_w[i]))
                    hit = i;
            end
            exp_reads_q.push_back(hit < 0 ? NOBJ - 1 : hit);
            if (hit >= 0) begin
                e_type = int'(t_type[hit]); e_bot = 1'b0; e_rx = x; e_ry = y;
                return;
            end
            if (y + 1 >= 230 || x + d <= 4 || x + d >= 312) begin
                e_type = 0; e_bot = 1'b1; e_rx = x; e_ry = y;
                return;
            end
            x = x + d;
            y = y + 1;
        end
    endtask

    // ---------------- per-cycle compare process ----------------
    initial begin
        bit    prev_sdh, in_scan;
        int    rc;
        draw_t d;
        prev_sdh = 1'b0; in_scan = 1'b0; rc = 0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                prev_sdh = 1'b0;
                in_scan  = 1'b0;
            end else begin
                if (start_draw_hook && !prev_sdh) begin
                    if (in_scan) begin
                        check("scan_reads", rc, exp_reads_q.size() > 0 ? exp_reads_q.pop_front() : -1);
                        in_scan = 1'b0;
                    end
                    if (exp_q.size() == 0) begin
                        check("draw_unexpected", 1, 0);
                    end else begin
                        d = exp_q.pop_front();
                        check("hook_x", int'(hook_x), d.x);
                        check("hook_y", int'(hook_y), d.y);
                        check("erase_hook", int'(erase_hook), int'(d.er));
                        check("draw_type", int'(draw_type), 12);
                    end
                    if (erase_hook) n_erases++;
                    else n_draws++;
                end
                prev_sdh = start_draw_hook;
                if (reset_object_read) begin
                    in_scan = 1'b1;
                    rc = 0;
                end
                if (read_object_location) rc++;
                if (start_pull_back) begin
                    if (in_scan) begin
                        check("scan_reads", rc, exp_reads_q.size() > 0 ? exp_reads_q.pop_front() : -1);
                        in_scan = 1'b0;
                    end
                    n_pb++;
                    check("rel_x", int'(current_release_x), e_rx);
                    check("rel_y", int'(current_release_y), e_ry);
                    check("reach_bottom", int'(reach_bottom), int'(e_bot));
                    check("type_reached", int'(type_reached), e_type);
                    check("draws_left", exp_q.size(), 0);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic check_all_zero(input string tag);
        check({tag, "_sdh"},  int'(start_draw_hook), 0);
        check({tag, "_erase"}, int'(erase_hook), 0);
        check({tag, "_hx"},   int'(hook_x), 0);
        check({tag, "_hy"},   int'(hook_y), 0);
        check({tag, "_dtype"}, int'(draw_type), 0);
        check({tag, "_rst_rd"}, int'(reset_object_read), 0);
        check({tag, "_rd"},   int'(read_object_location), 0);
        check({tag, "_rx"},   int'(current_release_x), 0);
        check({tag, "_ry"},   int'(current_release_y), 0);
        check({tag, "_bot"},  int'(reach_bottom), 0);
        check({tag, "_type"}, int'(type_reached), 0);
        check({tag, "_spb"},  int'(start_pull_back), 0);
        check({tag, "_rdone"}, int'(release_done), 0);
    endtask

    task automatic pulse_start(input int x0, input int y0, input int d);
        @(negedge clk);
        start_release = 1'b1;
        launch_x = 9'(x0); launch_y = 8'(y0); dir_x = 3'(d);
        @(negedge clk);
        start_release = 1'b0;
        @(negedge clk);
        // Launch inputs are latched at LOAD; scramble them afterwards.
        launch_x = 9'd300; launch_y = 8'd7; dir_x = 3'd1;
    endtask

    task automatic run_release(input int x0, input int y0, input int d, input int pb_hold);
        bit got, stable;
        got = 1'b0;
        model_run(x0, y0, d);
        pulse_start(x0, y0, d);
        for (int cyc = 0; cyc < 30000; cyc++) begin
            start_release = (cyc == 20);
            if (start_pull_back) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        start_release = 1'b0;
        check("handoff_seen", int'(got), 1);
        if (!got) return;
        stable = 1'b1;
        for (int i = 0; i < pb_hold; i++) begin
            @(negedge clk);
            start_release = (i == 10);
            if (int'(current_release_x) != e_rx || int'(current_release_y) != e_ry ||
                reach_bottom != e_bot || int'(type_reached) != e_type ||
                start_pull_back || release_done || start_draw_hook)
                stable = 1'b0;
        end
        start_release = 1'b0;
        check("pb_hold_stable", int'(stable), 1);
        pull_back_done = 1'b1;
        @(negedge clk);
        pull_back_done = 1'b0;
        check("release_done_pulse", int'(release_done), 1);
        @(negedge clk);
        check("release_done_clear", int'(release_done), 0);
        check("rel_x_persist", int'(current_release_x), e_rx);
        $display("release launch=(%0d,%0d) dir=%0d -> rel=(%0d,%0d) bottom=%0d type=%0d",
                 x0, y0, d, current_release_x, current_release_y, reach_bottom, type_reached);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int d0, e0, p0;
        bit ok;
        clear_table();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        resetn = 1'b1;

        // 1: empty table, straight down to the bottom.
        d0 = n_draws; e0 = n_erases; p0 = n_pb;
        model_run(160, 40, 0);
        check("model_t1_entries", exp_q.size(), 380);
        run_release(160, 40, 0, 20);
        check("t1_draws", n_draws - d0, 190);
        check("t1_erases", n_erases - e0, 190);
        check("t1_pb_pulses", n_pb - p0, 1);
        check("t1_rel_x", int'(current_release_x), 160);
        check("t1_rel_y", int'(current_release_y), 229);
        check("t1_bottom", int'(reach_bottom), 1);
        check("t1_type", int'(type_reached), 0);

        // 2: large gold ahead, long pull-back hold.
        clear_table();
        set_entry(5, 8, 158, 6, 60, 11, 1'b1);
        d0 = n_draws; p0 = n_pb;
        run_release(160, 40, 0, 500);
        check("t2_draws", n_draws - d0, 11);
        check("t2_pb_pulses", n_pb - p0, 1);
        check("t2_rel_x", int'(current_release_x), 160);
        check("t2_rel_y", int'(current_release_y), 50);
        check("t2_bottom", int'(reach_bottom), 0);
        check("t2_type", int'(type_reached), 11);

        // 3: leftward diagonal into the left edge.
        clear_table();
        run_release(10, 40, -2, 20);
        check("t3_rel_x", int'(current_release_x), 6);
        check("t3_rel_y", int'(current_release_y), 42);
        check("t3_bottom", int'(reach_bottom), 1);

        // 4: reset during WAIT_STEP.
        model_run(100, 100, 0);
        pulse_start(100, 100, 0);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (start_draw_hook) ok = 1'b1;
            else @(negedge clk);
        end
        for (int i = 0; i < 100 && ok && start_draw_hook; i++) @(negedge clk);
        check("t4_in_wait_step", int'(ok && !start_draw_hook), 1);
        resetn = 1'b0;
        @(negedge clk);
        check_all_zero("midreset");
        exp_q.delete();
        exp_reads_q.delete();
        resetn = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (start_draw_hook || reset_object_read || start_pull_back || release_done) ok = 1'b0;
        end
        check("t4_idle_after_reset", int'(ok), 1);

        // 5: non-present match at idx 3, present match at idx 11 on launch row.
        clear_table();
        for (int i = 0; i < NOBJ; i++) set_entry(i, 2, 300, 1, 200, 10, 1'b1);
        set_entry(3, 20, 150, 5, 50, 14, 1'b0);
        set_entry(11, 20, 150, 5, 50, 13, 1'b1);
        model_run(160, 40, 0);
        check("model_t5_reads", exp_reads_q[0], 11);
        run_release(160, 40, 0, 20);
        check("t5_rel_x", int'(current_release_x), 160);
        check("t5_rel_y", int'(current_release_y), 40);
        check("t5_bottom", int'(reach_bottom), 0);
        check("t5_type", int'(type_reached), 13);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
